// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default operand width.
package serial_sub_pkg;

   localparam int DEF_WIDTH = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the bit underflows.
// Purely combinational; zero latency, no flow control.
module full_subtractor_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first serial a - b; start-to-done WIDTH+1 cycles, start ignored while busy/done (not queued).
// Optional signed overflow output via SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] difference,
   output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_res_sr;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             r_bout;
   logic [CW-1:0]    r_cnt;
   logic             w_d;
   logic             w_bout;
   logic [WIDTH-1:0] w_res_next;
   logic             w_last;

   full_subtractor_bit u_bit (
      .a    (r_a_sr[0]),
      .b    (r_b_sr[0]),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_bout)
   );

   assign w_res_next = {w_d, r_res_sr[WIDTH-1:1]};
   assign w_last     = (r_cnt == LAST_BIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign busy       = (r_state == S_RUN);
   assign done       = (r_state == S_DONE);
   assign difference = r_diff;
   assign borrow     = r_bout;

`ifdef SERIAL_SUB_OVERFLOW_EN
   logic r_a_msb;
   logic r_b_msb;
   logic r_ovf;

   assign overflow = r_ovf;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_res_sr <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_bout   <= 1'b0;
         r_cnt    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_ovf    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sr   <= a;
                  r_b_sr   <= b;
                  r_res_sr <= '0;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  r_a_msb  <= a[WIDTH-1];
                  r_b_msb  <= b[WIDTH-1];
`endif
               end
            end
            S_RUN: begin
               r_a_sr   <= r_a_sr >> 1;
               r_b_sr   <= r_b_sr >> 1;
               r_res_sr <= w_res_next;
               r_borrow <= w_bout;
               r_cnt    <= r_cnt + 1'b1;
               // Published results only move here, so they stay stable through RUN.
               if (w_last) begin
                  r_diff <= w_res_next;
                  r_bout <= w_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8 (table vectors plus hand-written corner sequences).
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] difference;
   logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic         overflow;
`endif

   int errors = 0;
   int checks = 0;
   logic [W-1:0] prev_diff = '0;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] ed;
      logic         eb;
      logic         eo;
   } vec_t;

   vec_t vecs [8];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .difference (difference),
      .borrow     (borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
      ,
      .overflow   (overflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One accepted operation; operands are scrambled right after acceptance.
   task automatic run_op(input vec_t v, input int idx);
      int nbusy;
      int ndone;
      int dlat;
      int nhold;
      nbusy = 0; ndone = 0; dlat = 0; nhold = 0;
      @(negedge clk);
      a = v.va; b = v.vb; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = ~v.va; b = ~v.vb;
      for (int i = 1; i <= W + 3; i++) begin
         if (i > 1) @(negedge clk);
         if (busy) begin
            nbusy++;
            if (difference !== prev_diff) nhold++;
         end
         if (done) begin
            ndone++;
            dlat = i;
         end
      end
      check($sformatf("v%0d_busy_cycles", idx), nbusy, W);
      check($sformatf("v%0d_done_pulses", idx), ndone, 1);
      check($sformatf("v%0d_done_latency", idx), dlat, W + 1);
      check($sformatf("v%0d_hold_in_run", idx), nhold, 0);
      check($sformatf("v%0d_difference", idx), difference, v.ed);
      check($sformatf("v%0d_borrow", idx), borrow, v.eb);
`ifdef SERIAL_SUB_OVERFLOW_EN
      check($sformatf("v%0d_overflow", idx), overflow, v.eo);
`endif
      prev_diff = v.ed;
   endtask

   initial begin
      int ndone;
      int nhold;
      int nbusy;
      int first_done;
      int last_done;
      vec_t v;

      vecs[0] = '{8'd5,   8'd3,   8'd2,   1'b0, 1'b0};
      vecs[1] = '{8'd3,   8'd5,   8'd254, 1'b1, 1'b0};
      vecs[2] = '{8'd0,   8'd255, 8'd1,   1'b1, 1'b0};
      vecs[3] = '{8'd200, 8'd200, 8'd0,   1'b0, 1'b0};
      vecs[4] = '{8'd0,   8'd1,   8'd255, 1'b1, 1'b0};
      vecs[5] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
      vecs[6] = '{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1};
      vecs[7] = '{8'hA5,  8'h5A,  8'h4B,  1'b0, 1'b1};

      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_difference", difference, 0);
      check("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
      check("rst_overflow", overflow, 0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 8; k++) run_op(vecs[k], k);

      // start and operand changes during RUN must be ignored
      ndone = 0; nhold = 0;
      @(negedge clk);
      a = 8'd10; b = 8'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= W + 3; i++) begin
         if (i > 1) @(negedge clk);
         if (i == 3) begin start = 1'b1; a = 8'd1; b = 8'd1; end
         if (i == 4) begin start = 1'b0; a = 8'd0; b = 8'd0; end
         if (busy && difference !== prev_diff) nhold++;
         if (done) ndone++;
      end
      check("midrun_done_pulses", ndone, 1);
      check("midrun_hold", nhold, 0);
      check("midrun_difference", difference, 6);
      check("midrun_idle_after", busy, 0);
      prev_diff = 8'd6;

      // start held high: back-to-back operations every W+2 cycles
      ndone = 0; first_done = 0; last_done = 0;
      @(negedge clk);
      a = 8'd7; b = 8'd2; start = 1'b1;
      for (int i = 1; i <= 2 * (W + 2); i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (first_done == 0) first_done = i;
            last_done = i;
         end
      end
      start = 1'b0;
      check("cont_done_pulses", ndone, 2);
      check("cont_first_done", first_done, W + 1);
      check("cont_period", last_done - first_done, W + 2);
      check("cont_difference", difference, 5);
      prev_diff = 8'd5;

      // asynchronous reset in the middle of RUN
      @(negedge clk);
      a = 8'd9; b = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_difference", difference, 0);
      check("abort_borrow", borrow, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0; nbusy = 0;
      for (int i = 0; i < W + 3; i++) begin
         @(negedge clk);
         if (done) ndone++;
         if (busy) nbusy++;
      end
      check("abort_no_done", ndone, 0);
      check("abort_no_busy", nbusy, 0);
      prev_diff = '0;
      v = '{8'd9, 8'd2, 8'd7, 1'b0, 1'b0};
      run_op(v, 99);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first N-bit subtractor that computes difference = a - b and a final borrow.
- Successor to the single-bit half subtractor: parametrised width, a registered borrow chain carried across clock cycles, and a start/done handshake.
- Sits in the datapath wherever area matters more than latency; one full-subtractor bit cell is reused for WIDTH cycles.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepted start
- b  input  WIDTH  subtrahend; captured on the accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result becomes valid
- difference  output  WIDTH  a - b mod 2^WIDTH; held until the next accepted start
- borrow  output  1  unsigned borrow-out (1 iff a < b); held like difference

Behaviour:
- Reset is asynchronous on rst_n low: state=IDLE, all operand/result/shift registers 0, bit counter 0, borrow register 0, busy=0, done=0, difference=0, borrow=0.
- Reset asserted mid-operation aborts immediately; there is no done pulse and no partial result is retained.
- FSM states: IDLE, RUN, DONE (2-bit encoding).
- IDLE with start=1 at edge E0:
  - capture a and b into shift registers;
  - clear borrow_reg and the counter;
  - clear the difference shift register;
  - go to RUN.
- IDLE with start=0: remain in IDLE; outputs hold.
- RUN, each edge:
  - compute d = a_sr[0] ^ b_sr[0] ^ borrow_reg;
  - compute bo = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow_reg);
  - shift a_sr and b_sr right by one;
  - shift d into the MSB of the result shift register;
  - borrow_reg <= bo; counter++.
- On the edge where counter == WIDTH-1, i.e. edge E_WIDTH:
  - process the last bit;
  - copy the result register to difference and bo to borrow;
  - go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- Timing summary:
  - busy=1 for exactly WIDTH cycles (after E0 through E_WIDTH);
  - done is high in the cycle following E_WIDTH;
  - start-to-done latency is WIDTH+1 cycles.
- Output holding: difference and borrow update only on the transition into DONE. They are stable during RUN and keep the previous result.
- start in RUN or DONE is ignored; it is not queued.
- start held high continuously: a new operation is accepted on the first IDLE cycle, giving one operation per WIDTH+2 cycles.
- Changes on a and b after acceptance have no effect on the result.
- Wrap-around: results are modulo 2^WIDTH, e.g. 0 - 1 gives all ones with borrow=1.
- Counter width is $clog2(WIDTH).

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- Defined:
  - adds output port overflow (1 bit), reset 0, updated alongside difference;
  - overflow = 1 iff the signed two's-complement result overflows, i.e. a[MSB] != b[MSB] and difference[MSB] != a[MSB];
  - the captured operand MSBs are retained for this purpose.
- Undefined: no overflow port and no extra registers; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default WIDTH constant.
- One combinational sub-module, full_subtractor_bit (ports a, b, bin, d, bout), implements the per-bit equations above. It is instantiated once in serial_subtractor.

Test Plan:
- WIDTH=8, a=5, b=3, start pulse:
  - busy high 8 cycles, done one cycle later;
  - difference=2, borrow=0.
- a=3, b=5 → difference=254 (0xFE), borrow=1.
- a=0, b=255 → difference=1, borrow=1.
- a=200, b=200 → difference=0, borrow=0.
- Start/operand changes during RUN:
  - a=10, b=4 accepted; at cycle 3 of RUN drive start=1 with a=1, b=1;
  - only one done pulse; difference=6;
  - the previous result is held during RUN.
- Reset mid-operation: start a=9, b=2, assert rst_n=0 at RUN cycle 4:
  - all outputs 0 immediately, no done;
  - release reset, start a=9, b=2 → difference=7.
- With SERIAL_SUB_OVERFLOW_EN:
  - a=0x80, b=0x01 → difference=0x7F, overflow=1;
  - a=0x05, b=0x03 → overflow=0.
